// File: rtl/lsu_pkg.sv
// Shared types for the memory-stage load/store unit: FSM states, funct3 codes, error codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    E_NONE     = 2'd0,
    E_MISALIGN = 2'd1,
    E_FUNCT3   = 2'd2,
    E_TIMEOUT  = 2'd3
  } err_code_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational access checker, byte-lane steering for stores and load extraction/extension.
module lsu_align import lsu_pkg::*; (
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output err_code_t   code,
  output logic [3:0]  sel,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    code = E_NONE;
    case (funct3)
      F3_B, F3_BU: code = E_NONE;
      F3_H, F3_HU: if (addr_lo[0]) code = E_MISALIGN;
      F3_W:        if (addr_lo != 2'b00) code = E_MISALIGN;
      default:     code = E_FUNCT3;
    endcase
    // Unsigned variants only exist for loads; illegal funct3 outranks misalignment.
    if (we && funct3[2]) code = E_FUNCT3;
  end

  always_comb begin
    sel        = 4'b1111;
    lane_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        sel        = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        sel        = 4'b0011 << {addr_lo[1], 1'b0};
        lane_wdata = {2{wdata[15:0]}};
      end
      default: begin
        sel        = 4'b1111;
        lane_wdata = wdata;
      end
    endcase
  end

  always_comb begin
    rd_byte = bus_rdata[7:0];
    case (addr_lo)
      2'd0: rd_byte = bus_rdata[7:0];
      2'd1: rd_byte = bus_rdata[15:8];
      2'd2: rd_byte = bus_rdata[23:16];
      2'd3: rd_byte = bus_rdata[31:24];
      default: rd_byte = bus_rdata[7:0];
    endcase
    rd_half = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    load_data = bus_rdata;
    case (funct3)
      F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
      F3_BU:   load_data = {24'd0, rd_byte};
      F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
      F3_HU:   load_data = {16'd0, rd_half};
      default: load_data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Single-beat Wishbone pipelined initiator for the memory stage; traps bad accesses without bus activity.
// Optional bus-cycle abort is compiled in with LSU_TIMEOUT_EN.
module wb_lsu_master import lsu_pkg::*; #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  mem_stall,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_wr_en,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [31:0]           wb_wr_data,
  output logic [3:0]            wb_wr_sel,
  input  logic                  wb_ack,
  input  logic                  wb_stall,
  input  logic [31:0]           wb_rd_data
);

  state_t     state;
  err_code_t  chk_code;
  logic [3:0] sel;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;
  logic       tmo_hit;
  logic       unused_bits;

  // Request fields are held stable by the stage until done, so extraction can read them live.
  lsu_align u_align (
    .we         (req_we),
    .funct3     (req_funct3),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .bus_rdata  (wb_rd_data),
    .code       (chk_code),
    .sel        (sel),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  assign mem_stall   = req_valid & ~done;
  assign unused_bits = ^{req_addr[31:ADDR_WIDTH], 8'(TIMEOUT_CYCLES)};

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;

  // Held at zero while idle, so it is clear on every entry to REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 8'd0;
    end else if (state == S_REQ || state == S_WAIT) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end else begin
      tmo_cnt <= 8'd0;
    end
  end

  assign tmo_hit = (state == S_REQ || state == S_WAIT) && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      rdata      <= 32'd0;
      err        <= 1'b0;
      err_code   <= 2'd0;
      wb_cyc     <= 1'b0;
      wb_stb     <= 1'b0;
      wb_wr_en   <= 1'b0;
      wb_addr    <= '0;
      wb_wr_data <= 32'd0;
      wb_wr_sel  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (chk_code == E_NONE) begin
              wb_cyc     <= 1'b1;
              wb_stb     <= 1'b1;
              wb_wr_en   <= req_we;
              wb_addr    <= req_addr[ADDR_WIDTH-1:0];
              wb_wr_data <= lane_wdata;
              wb_wr_sel  <= sel;
              state      <= S_REQ;
            end else begin
              rdata    <= 32'd0;
              err      <= 1'b1;
              err_code <= chk_code;
              done     <= 1'b1;
              state    <= S_RESP;
            end
          end
        end
        S_REQ: begin
          // Any ack seen here belongs to nobody we are waiting on and is dropped.
          if (tmo_hit) begin
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            rdata    <= 32'd0;
            err      <= 1'b1;
            err_code <= E_TIMEOUT;
            done     <= 1'b1;
            state    <= S_RESP;
          end else if (!wb_stall) begin
            wb_stb <= 1'b0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wb_ack) begin
            wb_cyc   <= 1'b0;
            rdata    <= wb_wr_en ? 32'd0 : load_data;
            err      <= 1'b0;
            err_code <= E_NONE;
            done     <= 1'b1;
            state    <= S_RESP;
          end else if (tmo_hit) begin
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            rdata    <= 32'd0;
            err      <= 1'b1;
            err_code <= E_TIMEOUT;
            done     <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Bench for wb_lsu_master: Wishbone responder with a word memory, byte-level reference model, directed and random accesses.
module tb_wb_lsu_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        mem_stall, done, err;
  logic [31:0] rdata;
  logic [1:0]  err_code;
  logic        wb_cyc, wb_stb, wb_wr_en;
  logic [9:0]  wb_addr;
  logic [31:0] wb_wr_data;
  logic [3:0]  wb_wr_sel;
  logic        wb_ack = 1'b0;
  logic        wb_stall = 1'b0;
  logic [31:0] wb_rd_data = 32'd0;

  int checks = 0;
  int errors = 0;

  wb_lsu_master #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_stall(mem_stall), .done(done), .rdata(rdata), .err(err), .err_code(err_code),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_wr_en(wb_wr_en), .wb_addr(wb_addr),
    .wb_wr_data(wb_wr_data), .wb_wr_sel(wb_wr_sel),
    .wb_ack(wb_ack), .wb_stall(wb_stall), .wb_rd_data(wb_rd_data)
  );

  always #5 clk = ~clk;

  // Responder: word memory on the bus side, plus the reference byte image kept by the bench.
  logic [31:0] mem [256];
  logic [7:0]  ref_mem [1024];
  int stall_left = 0;
  int ack_delay = 1;
  int cnt = 0;
  bit pend = 0;
  bit ack_never = 0;
  bit ack_on_accept = 0;

  always @(negedge clk) begin
    wb_ack   = 1'b0;
    wb_stall = 1'b0;
    if (!wb_cyc) begin
      pend = 0;
    end else if (wb_stb) begin
      if (stall_left > 0) begin
        wb_stall = 1'b1;
        stall_left--;
      end else begin
        pend = 1;
        cnt  = ack_delay;
        if (ack_on_accept) begin
          wb_ack     = 1'b1;
          wb_rd_data = $urandom;
        end
      end
    end else if (pend) begin
      cnt--;
      if (cnt <= 0 && !ack_never) begin
        wb_ack = 1'b1;
        pend   = 0;
        if (wb_wr_en) begin
          for (int b = 0; b < 4; b++)
            if (wb_wr_sel[b]) mem[wb_addr[9:2]][8*b +: 8] = wb_wr_data[8*b +: 8];
          wb_rd_data = $urandom;
        end else begin
          wb_rd_data = mem[wb_addr[9:2]];
        end
      end
    end
  end

  // Reference model at byte granularity.
  function automatic int exp_code(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2;
    size = 1 << f3[1:0];
    if ((a & (size - 1)) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int size;
    int base;
    logic [31:0] v;
    size = 1 << f3[1:0];
    base = int'(a[9:0]);
    v = 32'd0;
    for (int k = 0; k < size; k++) v = v | (32'(ref_mem[base + k]) << (8 * k));
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int size;
    int base;
    size = 1 << f3[1:0];
    base = int'(a[9:0]);
    for (int k = 0; k < size; k++) ref_mem[base + k] = d[8*k +: 8];
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
    for (int k = 0; k < 4; k++) ref_mem[{a[9:2], 2'b00} + k] = w[8*k +: 8];
  endtask

  // Results of the last access.
  int          o_done, o_stb, o_cyc;
  bit          o_saw, o_stall_bad, o_stall_done, o_err, o_we;
  logic [31:0] o_rdata, o_wdat;
  logic [1:0]  o_code;
  logic [3:0]  o_sel;
  logic [9:0]  o_addr;

  // Cycle 0 is the cycle req_valid is first presented.
  task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int stalls, input int ackd, input int rel_at);
    @(negedge clk);
    stall_left = stalls;
    ack_delay  = ackd;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    o_done = -1; o_saw = 0; o_stb = 0; o_cyc = 0; o_stall_bad = 0; o_stall_done = 1;
    for (int i = 0; i < 300; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      if (i == rel_at) ack_never = 0;
      if (wb_cyc && !o_saw) begin
        o_saw = 1; o_sel = wb_wr_sel; o_wdat = wb_wr_data; o_addr = wb_addr; o_we = wb_wr_en;
      end
      if (wb_stb) o_stb++;
      if (wb_cyc) o_cyc++;
      if (done) begin
        o_done = i; o_rdata = rdata; o_err = err; o_code = err_code; o_stall_done = mem_stall;
        break;
      end
      if (!mem_stall) o_stall_bad = 1;
    end
    req_valid = 1'b0;
    checks++;
    if (o_done < 0) begin
      errors++;
      $display("FAIL access_bound: no done within 300 cycles (addr %h f3 %0d)", a, f3);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({wb_cyc, wb_stb, wb_wr_en, wb_addr, wb_wr_data, wb_wr_sel, done, rdata, err, err_code} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: cyc %b stb %b we %b addr %h wd %h sel %b done %b rdata %h err %b code %0d, want all 0",
               wb_cyc, wb_stb, wb_wr_en, wb_addr, wb_wr_data, wb_wr_sel, done, rdata, err, err_code);
    end
    checks++;
    if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_mem_stall: got %b want 0", mem_stall); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word;
    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1, -1);
    ref_store(3'b010, 32'h10, 32'hDEADBEEF);
    checks++;
    if (o_sel !== 4'b1111 || o_wdat !== 32'hDEADBEEF || o_we !== 1'b1 || o_addr !== 10'h10) begin
      errors++; $display("FAIL sw_bus: sel %b wd %h we %b addr %h, want 1111 deadbeef 1 010", o_sel, o_wdat, o_we, o_addr);
    end
    checks++;
    if (o_done !== 3 || o_err !== 1'b0 || o_rdata !== 32'd0) begin
      errors++; $display("FAIL sw_done: cycle %0d err %b rdata %h, want 3 0 0", o_done, o_err, o_rdata);
    end
    checks++;
    if (o_stall_bad || o_stall_done) begin
      errors++; $display("FAIL sw_mem_stall: low_early %b high_at_done %b, want 0 0", o_stall_bad, o_stall_done);
    end
    // Issued at the cycle right after done, so this also covers back-to-back acceptance.
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, 1, -1);
    checks++;
    if (o_done !== 3 || o_rdata !== 32'hDEADBEEF || o_err !== 1'b0) begin
      errors++; $display("FAIL lw_back_to_back: cycle %0d rdata %h err %b, want 3 deadbeef 0", o_done, o_rdata, o_err);
    end
  endtask

  task automatic test_byte;
    preload(32'h10, 32'h80123456);
    access(1'b0, 3'b000, 32'h13, 32'h0, 0, 1, -1);
    checks++;
    if (o_sel !== 4'b1000 || o_rdata !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb: sel %b rdata %h, want 1000 ffffff80", o_sel, o_rdata);
    end
    access(1'b0, 3'b100, 32'h13, 32'h0, 0, 1, -1);
    checks++;
    if (o_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu: rdata %h want 00000080", o_rdata); end
  endtask

  task automatic test_half;
    access(1'b1, 3'b001, 32'h06, 32'h0000ABCD, 0, 1, -1);
    ref_store(3'b001, 32'h06, 32'h0000ABCD);
    checks++;
    if (o_sel !== 4'b1100 || o_wdat !== 32'hABCDABCD) begin
      errors++; $display("FAIL sh: sel %b wd %h, want 1100 abcdabcd", o_sel, o_wdat);
    end
    access(1'b0, 3'b101, 32'h06, 32'h0, 0, 1, -1);
    checks++;
    if (o_rdata !== 32'h0000ABCD) begin errors++; $display("FAIL lhu: rdata %h want 0000abcd", o_rdata); end
  endtask

  task automatic test_illegal;
    access(1'b0, 3'b010, 32'h02, 32'h0, 0, 1, -1);
    checks++;
    if (o_saw || o_done !== 1 || o_err !== 1'b1 || o_code !== 2'd1) begin
      errors++; $display("FAIL lw_misaligned: cyc_seen %b cycle %0d err %b code %0d, want 0 1 1 1", o_saw, o_done, o_err, o_code);
    end
    access(1'b0, 3'b011, 32'h20, 32'h0, 0, 1, -1);
    checks++;
    if (o_saw || o_done !== 1 || o_err !== 1'b1 || o_code !== 2'd2) begin
      errors++; $display("FAIL load_f3_011: cyc_seen %b cycle %0d err %b code %0d, want 0 1 1 2", o_saw, o_done, o_err, o_code);
    end
    access(1'b1, 3'b101, 32'h21, 32'h0, 0, 1, -1);
    checks++;
    if (o_saw || o_err !== 1'b1 || o_code !== 2'd2) begin
      errors++; $display("FAIL store_f3_precedence: cyc_seen %b err %b code %0d, want 0 1 2", o_saw, o_err, o_code);
    end
  endtask

  task automatic test_stall;
    access(1'b0, 3'b010, 32'h10, 32'h0, 3, 1, -1);
    checks++;
    if (o_done !== 6 || o_stb !== 4 || o_rdata !== ref_load(3'b010, 32'h10)) begin
      errors++; $display("FAIL stall3: done %0d stb_cycles %0d rdata %h, want 6 4 %h", o_done, o_stb, o_rdata, ref_load(3'b010, 32'h10));
    end
  endtask

  task automatic test_spurious_ack;
    ack_on_accept = 1;
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, 3, -1);
    ack_on_accept = 0;
    checks++;
    if (o_done !== 5 || o_rdata !== ref_load(3'b010, 32'h10)) begin
      errors++; $display("FAIL ack_on_accept: done %0d rdata %h, want 5 %h", o_done, o_rdata, ref_load(3'b010, 32'h10));
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    ack_never = 1;
    access(1'b0, 3'b010, 32'h20, 32'h0, 0, 1, -1);
    ack_never = 0;
    checks++;
    if (o_cyc !== 15 || o_done !== 16 || o_err !== 1'b1 || o_code !== 2'd3) begin
      errors++; $display("FAIL timeout: cyc_cycles %0d done %0d err %b code %0d, want 15 16 1 3", o_cyc, o_done, o_err, o_code);
    end
  endtask
`else
  task automatic test_timeout;
    ack_never = 1;
    access(1'b0, 3'b010, 32'h20, 32'h0, 0, 1, 40);
    checks++;
    if (o_cyc !== 41 || o_done !== 42 || o_err !== 1'b0 || o_rdata !== ref_load(3'b010, 32'h20)) begin
      errors++; $display("FAIL no_timeout: cyc_cycles %0d done %0d err %b rdata %h, want 41 42 0 %h",
                         o_cyc, o_done, o_err, o_rdata, ref_load(3'b010, 32'h20));
    end
  endtask
`endif

  task automatic test_reset_mid;
    bit bad;
    @(negedge clk);
    ack_never  = 1;
    stall_left = 0;
    ack_delay  = 1;
    req_valid  = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h12345678;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (wb_cyc !== 1'b1 || wb_stb !== 1'b0) begin
      errors++; $display("FAIL mid_reset_setup: cyc %b stb %b, want 1 0", wb_cyc, wb_stb);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_cyc, wb_stb, wb_wr_en, wb_addr, wb_wr_data, wb_wr_sel, done, rdata, err, err_code} !== '0) begin
      errors++; $display("FAIL mid_reset_async: cyc %b stb %b we %b wd %h sel %b done %b err %b, want all 0",
                         wb_cyc, wb_stb, wb_wr_en, wb_wr_data, wb_wr_sel, done, err);
    end
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_never = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2;
      if (done || wb_cyc) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL mid_reset_not_reported: done or cyc seen after reset, want none"); end
  endtask

  task automatic test_random;
    bit we;
    logic [2:0] f3;
    logic [31:0] a, d, exp_rd;
    int stalls, ackd, code, size, sh;
    logic [3:0] es;
    bit lanes_ok;
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      d  = $urandom;
      stalls = $urandom_range(0, 2);
      ackd   = $urandom_range(1, 3);
      code   = exp_code(we, f3, a);
      exp_rd = (code == 0 && !we) ? ref_load(f3, a) : 32'd0;
      access(we, f3, a, d, stalls, ackd, -1);
      if (code != 0) begin
        checks++;
        if (o_saw || o_done !== 1 || o_err !== 1'b1 || o_code !== 2'(code)) begin
          errors++; $display("FAIL rand_trap[%0d]: we %b f3 %0d addr %h -> cyc_seen %b done %0d err %b code %0d, want 0 1 1 %0d",
                             n, we, f3, a, o_saw, o_done, o_err, o_code, code);
        end
      end else begin
        size = 1 << f3[1:0];
        sh   = int'(a[1:0]);
        es   = 4'(((1 << size) - 1) << sh);
        lanes_ok = 1;
        for (int k = 0; k < 4; k++)
          if (es[k] && o_wdat[8*k +: 8] !== d[8*(k-sh) +: 8]) lanes_ok = 0;
        checks++;
        if (o_sel !== es || o_addr !== a[9:0] || o_we !== we || (we && !lanes_ok)) begin
          errors++; $display("FAIL rand_bus[%0d]: f3 %0d addr %h sel %b/%b baddr %h we %b lanes_ok %b",
                             n, f3, a, o_sel, es, o_addr, o_we, lanes_ok);
        end
        checks++;
        if (o_done !== 2 + stalls + ackd || o_err !== 1'b0 || o_code !== 2'd0 || o_rdata !== exp_rd ||
            o_stall_bad || o_stall_done) begin
          errors++; $display("FAIL rand_resp[%0d]: we %b f3 %0d addr %h done %0d/%0d err %b code %0d rdata %h/%h stall %b%b",
                             n, we, f3, a, o_done, 2 + stalls + ackd, o_err, o_code, o_rdata, exp_rd, o_stall_bad, o_stall_done);
        end
        if (we) ref_store(f3, a, d);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) preload(32'(i * 4), $urandom);
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_illegal();
    test_stall();
    test_spurious_ack();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_lsu_master.md
# wb_lsu_master

Wishbone pipelined-mode initiator for pipeline stage 4 (MEMORY). Takes one load/store request from the stage, generates byte selects and lane-replicated write data, and runs a single-beat bus cycle against the data port of the main memory. It waits for acknowledge, then returns sign- or zero-extended load data. Misaligned or illegal accesses are trapped without any bus activity.

## Interface
- ADDR_WIDTH, 10: byte-address width of the data bus; 1 KiB memory.
- TIMEOUT_CYCLES, 15: with LSU_TIMEOUT_EN, the number of cycles in REQ+WAIT before abort; range 1..255.
- clk in 1: sole clock, rising edge.
- rst_n in 1: asynchronous, active-low reset.
- req_valid in 1: stage 4 holds a memory instruction; request fields stay stable until done.
- req_we in 1: 1 = store, 0 = load.
- req_funct3 in 3: RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr in 32: effective byte address.
- req_wdata in 32: rs2 value for stores.
- mem_stall out 1: combinational `req_valid & ~done`; freezes the pipeline.
- done out 1: one-cycle pulse; result or error valid.
- rdata out 32: extended load data, valid with done; 0 for stores.
- err out 1: access faulted, valid with done.
- err_code out 2: 0 none, 1 misaligned, 2 illegal funct3, 3 timeout.
- wb_cyc, wb_stb, wb_wr_en out 1: Wishbone controls.
- wb_addr out ADDR_WIDTH: `req_addr[ADDR_WIDTH-1:0]`, full byte address.
- wb_wr_data out 32, wb_wr_sel out 4: lane data and byte enables.
- wb_ack, wb_stall in 1; wb_rd_data in 32: responder returns.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If req_valid and the access is legal: register the wb_* fields, set cyc=stb=1, go to REQ.
  - If req_valid and the access is illegal: go to RESP with err set; no bus cycle.
- REQ: stb held high. When `~wb_stall`, drop stb, keep cyc, go to WAIT.
- WAIT: on wb_ack, drop cyc, capture extended data, go to RESP. wb_ack seen in IDLE or REQ is ignored.
- RESP: done=1 for exactly one cycle, then IDLE. A request cannot be accepted in RESP.
- Legality rules:
  - funct3 011/110/111 is illegal for loads.
  - Any funct3 other than 000/001/010 is illegal for stores.
  - H accesses require addr[0]=0; W accesses require addr[1:0]=0.
  - If both apply, illegal funct3 takes precedence over misalignment.
- Byte selects: B = 0001<<addr[1:0]; H = 0011<<{addr[1],0}; W = 1111. The same selects are driven for loads.
- Write data: SB = {4{wdata[7:0]}}, SH = {2{wdata[15:0]}}, SW = wdata.
- Load extraction: shift wb_rd_data right by 8*addr[1:0], take 8 or 16 bits, then extend:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes through unchanged.

## Timing
- All wb_* outputs, done, rdata, err and err_code are registered; mem_stall is combinational.
- Reset values: every registered output is 0 and the state is IDLE. Asserting rst_n mid-cycle drops cyc/stb immediately; the aborted request is not reported.
- Legal access with zero stall and 1-cycle ack:
  - req_valid at cycle 0, cyc/stb at cycle 1, ack at cycle 2, done at cycle 3.
  - mem_stall is high for cycles 0–2 and low at cycle 3.
- Each cycle of wb_stall extends REQ by one cycle.
- Illegal access: req_valid at cycle 0, done+err at cycle 1.
- Back-to-back: the next instruction may present req_valid at cycle 4 and is accepted there.
- If wb_ack arrives in the same cycle that stb is accepted, it is ignored. The LSU then waits for a later ack, or times out under LSU_TIMEOUT_EN.

## Configuration
- LSU_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to REQ and increments in REQ and WAIT.
  - When it reaches TIMEOUT_CYCLES, cyc and stb drop and the FSM goes to RESP with err=1, err_code=3.
  - A late ack arriving in RESP or IDLE is ignored.
- LSU_TIMEOUT_EN undefined: no counter; WAIT and REQ hold indefinitely; err_code 3 never occurs.

## Structure
- lsu_pkg holds:
  - the state enum,
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU),
  - the err_code enum.
- One combinational sub-module, lsu_align, contains the legality check, select/write-data generation and load extraction/extension.
- wb_lsu_master contains the FSM, the registers and the optional timeout.

## Test plan
- SW addr 0x10, wdata 0xDEADBEEF → sel 1111, wr_data 0xDEADBEEF, done at cycle 3, err=0; a following LW from 0x10 returns 0xDEADBEEF.
- LB addr 0x13 with word 0x80_12_34_56 → sel 1000, rdata 0xFFFFFF80; LBU gives 0x00000080.
- SH addr 0x06, wdata 0x0000ABCD → sel 1100, wr_data 0xABCDABCD; LHU addr 0x06 returns 0x0000ABCD.
- LW addr 0x02 → no cyc, done+err at cycle 1, err_code=1; funct3 011 load → err_code=2.
- wb_stall held 3 cycles → stb held through the stall, done at cycle 6.
- Under LSU_TIMEOUT_EN, ack never arrives → cyc drops after 15 cycles, err_code=3; rst_n pulsed in WAIT → all outputs 0 asynchronously.
